// File: rtl/mem_access_ctrl_if.sv
// Data-bus interface between the memory-access stage and the data memory.
//   dbus_req   : request strobe, held high until the ack cycle
//   dbus_we    : write strobe (stores)
//   dbus_addr  : word-aligned byte address (bits [1:0] are zero)
//   dbus_be    : byte enables, one bit per byte lane
//   dbus_wdata : store data, already replicated onto the addressed lanes
//   dbus_ack   : completion strobe from the memory
//   dbus_rdata : read word, valid with dbus_ack
// The master modport is used by the controller; the slave modport by the memory.
interface mem_access_ctrl_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-access pipeline stage. Non-memory results pass through with one
// cycle of latency; loads and stores issue one data-bus transaction and stall
// upstream until the bus acks or the timeout expires. Misaligned accesses and
// bus timeouts are reported as exceptions on the registered stage outputs.
//   clk, reset        : clock, asynchronous active-low reset
//   ex_*              : upstream EX-stage valid, PC, instruction, ALU result /
//                       effective address, writeback control, op code, store data
//   mem_flush         : kills the current or pending result
//   dbus              : data-bus master port (see mem_access_ctrl_if)
//   mem_busy          : combinational stall to upstream
//   mem_*             : registered stage outputs towards writeback
//   mem_exc/_code     : exception flag; 1 load misaligned, 2 store misaligned,
//                       3 bus timeout
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_en,
    input  logic [29:0]       ex_pc,
    input  logic [31:0]       ex_insn,
    input  logic [31:0]       ex_alu_out,
    input  logic              ex_gpr_we_,
    input  logic [4:0]        ex_dst_addr,
    input  logic [3:0]        ex_mem_op,
    input  logic [31:0]       ex_gpr_data,
    input  logic              mem_flush,
    mem_access_ctrl_if.master dbus,
    output logic              mem_busy,
    output logic              mem_en,
    output logic [29:0]       mem_pc,
    output logic [31:0]       mem_insn,
    output logic [31:0]       mem_out,
    output logic              mem_gpr_we_,
    output logic [4:0]        mem_dst_addr,
    output logic              mem_exc,
    output logic [1:0]        mem_exc_code
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LH  = 4'd2,
        OP_LW  = 4'd3,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } op_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        flush_q;

    // Latched request, used to build the result when the bus completes.
    op_e         req_op_q;
    logic [31:0] req_addr_q;
    logic [29:0] req_pc_q;
    logic [31:0] req_insn_q;
    logic [4:0]  req_dst_q;
    logic        req_gpr_we_q;

    logic        dbus_req_q;
    logic        dbus_we_q;
    logic [31:0] dbus_addr_q;
    logic [3:0]  dbus_be_q;
    logic [31:0] dbus_wdata_q;

    logic        mem_en_q;
    logic [29:0] mem_pc_q;
    logic [31:0] mem_insn_q;
    logic [31:0] mem_out_q;
    logic        mem_gpr_we_q;
    logic [4:0]  mem_dst_q;
    logic        mem_exc_q;
    logic [1:0]  mem_exc_code_q;

    // Request decode of the incoming EX-stage operation.
    op_e         ex_op;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    assign ex_op = op_e'(ex_mem_op);

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = '0;
        case (ex_op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                misaligned = ex_alu_out[0];
            end
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = |ex_alu_out[1:0];
            end
            OP_SB: begin
                is_store = 1'b1;
                be_d     = 4'b0001 << ex_alu_out[1:0];
                wdata_d  = {4{ex_gpr_data[7:0]}};
            end
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = ex_alu_out[0];
                be_d       = 4'b0011 << ex_alu_out[1:0];
                wdata_d    = {2{ex_gpr_data[15:0]}};
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = |ex_alu_out[1:0];
                wdata_d    = ex_gpr_data;
            end
            default: ;
        endcase
    end

    // Lane selection and extension of the returned read word.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic        req_is_store;

    assign rd_byte      = dbus.dbus_rdata[{req_addr_q[1:0], 3'b000} +: 8];
    assign rd_half      = dbus.dbus_rdata[{req_addr_q[1], 4'b0000} +: 16];
    assign req_is_store = (req_op_q == OP_SB) || (req_op_q == OP_SH) ||
                          (req_op_q == OP_SW);

    always_comb begin
        case (req_op_q)
            OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_data = {24'b0, rd_byte};
            OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_data = {16'b0, rd_half};
            default: load_data = dbus.dbus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            flush_q        <= 1'b0;
            req_op_q       <= OP_NOP;
            req_addr_q     <= '0;
            req_pc_q       <= '0;
            req_insn_q     <= '0;
            req_dst_q      <= '0;
            req_gpr_we_q   <= 1'b0;
            dbus_req_q     <= 1'b0;
            dbus_we_q      <= 1'b0;
            dbus_addr_q    <= '0;
            dbus_be_q      <= '0;
            dbus_wdata_q   <= '0;
            mem_en_q       <= 1'b0;
            mem_pc_q       <= '0;
            mem_insn_q     <= '0;
            mem_out_q      <= '0;
            mem_gpr_we_q   <= 1'b0;
            mem_dst_q      <= '0;
            mem_exc_q      <= 1'b0;
            mem_exc_code_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_flush || !ex_en) begin
                        mem_en_q <= 1'b0;
                    end else if (!is_load && !is_store) begin
                        mem_en_q       <= 1'b1;
                        mem_pc_q       <= ex_pc;
                        mem_insn_q     <= ex_insn;
                        mem_out_q      <= ex_alu_out;
                        mem_gpr_we_q   <= ex_gpr_we_;
                        mem_dst_q      <= ex_dst_addr;
                        mem_exc_q      <= 1'b0;
                        mem_exc_code_q <= '0;
                    end else if (misaligned) begin
                        mem_en_q       <= 1'b1;
                        mem_pc_q       <= ex_pc;
                        mem_insn_q     <= ex_insn;
                        mem_out_q      <= ex_alu_out;
                        mem_gpr_we_q   <= 1'b1;
                        mem_dst_q      <= ex_dst_addr;
                        mem_exc_q      <= 1'b1;
                        mem_exc_code_q <= is_store ? 2'd2 : 2'd1;
                    end else begin
                        state_q      <= BUSY;
                        cnt_q        <= '0;
                        flush_q      <= 1'b0;
                        req_op_q     <= ex_op;
                        req_addr_q   <= ex_alu_out;
                        req_pc_q     <= ex_pc;
                        req_insn_q   <= ex_insn;
                        req_dst_q    <= ex_dst_addr;
                        req_gpr_we_q <= ex_gpr_we_;
                        dbus_req_q   <= 1'b1;
                        dbus_we_q    <= is_store;
                        dbus_addr_q  <= {ex_alu_out[31:2], 2'b00};
                        dbus_be_q    <= be_d;
                        dbus_wdata_q <= wdata_d;
                        mem_en_q     <= 1'b0;
                    end
                end

                BUSY: begin
                    // A flush cannot cancel a bus transaction already in
                    // flight; it only suppresses the eventual result.
                    if (mem_flush) begin
                        flush_q <= 1'b1;
                    end
                    if (dbus.dbus_ack || (cnt_q == TO_LAST)) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        flush_q    <= 1'b0;
                        dbus_req_q <= 1'b0;
                        dbus_we_q  <= 1'b0;
                        if (flush_q || mem_flush) begin
                            mem_en_q       <= 1'b0;
                            mem_exc_q      <= 1'b0;
                            mem_exc_code_q <= '0;
                        end else begin
                            mem_en_q  <= 1'b1;
                            mem_pc_q  <= req_pc_q;
                            mem_insn_q <= req_insn_q;
                            mem_dst_q <= req_dst_q;
                            if (dbus.dbus_ack) begin
                                mem_exc_q      <= 1'b0;
                                mem_exc_code_q <= '0;
                                if (req_is_store) begin
                                    mem_out_q    <= req_addr_q;
                                    mem_gpr_we_q <= 1'b1;
                                end else begin
                                    mem_out_q    <= load_data;
                                    mem_gpr_we_q <= req_gpr_we_q;
                                end
                            end else begin
                                mem_out_q      <= req_addr_q;
                                mem_gpr_we_q   <= 1'b1;
                                mem_exc_q      <= 1'b1;
                                mem_exc_code_q <= 2'd3;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_busy        = (state_q == BUSY) && !dbus.dbus_ack;

    assign dbus.dbus_req   = dbus_req_q;
    assign dbus.dbus_we    = dbus_we_q;
    assign dbus.dbus_addr  = dbus_addr_q;
    assign dbus.dbus_be    = dbus_be_q;
    assign dbus.dbus_wdata = dbus_wdata_q;

    assign mem_en          = mem_en_q;
    assign mem_pc          = mem_pc_q;
    assign mem_insn        = mem_insn_q;
    assign mem_out         = mem_out_q;
    assign mem_gpr_we_     = mem_gpr_we_q;
    assign mem_dst_addr    = mem_dst_q;
    assign mem_exc         = mem_exc_q;
    assign mem_exc_code    = mem_exc_code_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with TIMEOUT_CYCLES=4. Stimulus pushes
// expected stage results and bus requests into queues; two monitor processes
// pop and compare whenever the DUT presents mem_en or a new dbus_req.
module tb_mem_access_ctrl;

    typedef struct {
        logic [31:0] out;
        logic        gpr_we_;
        logic [4:0]  dst;
        logic [29:0] pc;
        logic        exc;
        logic [1:0]  code;
        bit          chk_out;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_en = 1'b0;
    logic [29:0] ex_pc = '0;
    logic [31:0] ex_insn = '0;
    logic [31:0] ex_alu_out = '0;
    logic        ex_gpr_we_ = 1'b1;
    logic [4:0]  ex_dst_addr = '0;
    logic [3:0]  ex_mem_op = '0;
    logic [31:0] ex_gpr_data = '0;
    logic        mem_flush = 1'b0;
    logic        mem_busy;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic [31:0] mem_insn;
    logic [31:0] mem_out;
    logic        mem_gpr_we_;
    logic [4:0]  mem_dst_addr;
    logic        mem_exc;
    logic [1:0]  mem_exc_code;

    int tests = 0;
    int fails = 0;
    res_t exp_q[$];
    bus_t bus_q[$];

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_en        (ex_en),
        .ex_pc        (ex_pc),
        .ex_insn      (ex_insn),
        .ex_alu_out   (ex_alu_out),
        .ex_gpr_we_   (ex_gpr_we_),
        .ex_dst_addr  (ex_dst_addr),
        .ex_mem_op    (ex_mem_op),
        .ex_gpr_data  (ex_gpr_data),
        .mem_flush    (mem_flush),
        .dbus         (bus),
        .mem_busy     (mem_busy),
        .mem_en       (mem_en),
        .mem_pc       (mem_pc),
        .mem_insn     (mem_insn),
        .mem_out      (mem_out),
        .mem_gpr_we_  (mem_gpr_we_),
        .mem_dst_addr (mem_dst_addr),
        .mem_exc      (mem_exc),
        .mem_exc_code (mem_exc_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] insn_of(input logic [29:0] pc);
        return 32'h1000_0000 | {2'b00, pc};
    endfunction

    task automatic exp_res(input logic [31:0] out, input logic gpr_we_, input logic [4:0] dst,
                           input logic [29:0] pc, input logic exc, input logic [1:0] code,
                           input bit chk_out);
        res_t r;
        r.out = out; r.gpr_we_ = gpr_we_; r.dst = dst; r.pc = pc;
        r.exc = exc; r.code = code; r.chk_out = chk_out;
        exp_q.push_back(r);
    endtask

    task automatic exp_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                           input logic [31:0] wdata);
        bus_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [29:0] pc, input logic [4:0] dst, input logic gpr_we_);
        ex_en       = 1'b1;
        ex_mem_op   = op;
        ex_alu_out  = addr;
        ex_gpr_data = data;
        ex_pc       = pc;
        ex_insn     = insn_of(pc);
        ex_dst_addr = dst;
        ex_gpr_we_  = gpr_we_;
    endtask

    // Single-cycle issue (non-memory op, misaligned access, or flushed issue).
    task automatic issue1(input logic [3:0] op, input logic [31:0] addr, input logic [29:0] pc,
                          input logic [4:0] dst, input logic gpr_we_, input logic flush);
        drive(op, addr, 32'h0, pc, dst, gpr_we_);
        mem_flush = flush;
        @(posedge clk); #1;
        ex_en     = 1'b0;
        mem_flush = 1'b0;
    endtask

    // Aligned memory op. ack_after<0 means the bus never acks. Upstream fields
    // are scrambled once the request is accepted so latching is exercised.
    task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [29:0] pc, input logic [4:0] dst, input int ack_after,
                           input logic [31:0] rdata, input int flush_at, input int exp_busy);
        int  busy;
        bit  stop;
        busy = 0;
        stop = 1'b0;
        drive(op, addr, data, pc, dst, 1'b0);
        @(posedge clk); #1;
        ex_en       = 1'b0;
        ex_alu_out  = 32'hDEAD_BEEF;
        ex_gpr_data = 32'h5555_5555;
        ex_dst_addr = 5'd31;
        for (int c = 0; c < 20; c++) begin
            mem_flush       = (c == flush_at);
            bus.dbus_ack    = (c == ack_after);
            bus.dbus_rdata  = rdata;
            @(negedge clk);
            stop = !mem_busy;
            if (mem_busy) busy++;
            @(posedge clk); #1;
            mem_flush    = 1'b0;
            bus.dbus_ack = 1'b0;
            if (stop) break;
        end
        chk("busy_cycles", busy, exp_busy);
    endtask

    // Result monitor.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (reset && mem_en) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result: got mem_en=1 out=%h expected no result at %0t",
                             mem_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_out) chk("mem_out", mem_out, e.out);
                    chk("mem_gpr_we_", 32'(mem_gpr_we_), 32'(e.gpr_we_));
                    chk("mem_dst_addr", 32'(mem_dst_addr), 32'(e.dst));
                    chk("mem_pc", 32'(mem_pc), 32'(e.pc));
                    chk("mem_insn", mem_insn, insn_of(e.pc));
                    chk("mem_exc", 32'(mem_exc), 32'(e.exc));
                    if (e.exc) chk("mem_exc_code", 32'(mem_exc_code), 32'(e.code));
                end
            end
        end
    end

    // Bus monitor: checks each new request and its stability while held.
    initial begin
        bus_t e;
        bus_t snap;
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dbus_req && !req_prev) begin
                tests++;
                snap.addr = bus.dbus_addr; snap.be = bus.dbus_be;
                snap.we = bus.dbus_we; snap.wdata = bus.dbus_wdata;
                if (bus_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_bus_req: got addr=%h expected no request at %0t",
                             bus.dbus_addr, $time);
                end else begin
                    e = bus_q.pop_front();
                    chk("dbus_addr", bus.dbus_addr, e.addr);
                    chk("dbus_be", 32'(bus.dbus_be), 32'(e.be));
                    chk("dbus_we", 32'(bus.dbus_we), 32'(e.we));
                    if (e.we) chk("dbus_wdata", bus.dbus_wdata, e.wdata);
                end
            end else if (bus.dbus_req) begin
                chk("dbus_addr_stable", bus.dbus_addr, snap.addr);
                chk("dbus_be_stable", 32'(bus.dbus_be), 32'(snap.be));
                chk("dbus_wdata_stable", bus.dbus_wdata, snap.wdata);
            end
            req_prev = bus.dbus_req;
        end
    end

    initial begin
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = '0;
        #1 reset = 1'b0;
        #6;
        chk("rst_dbus_req", 32'(bus.dbus_req), 0);
        chk("rst_dbus_we", 32'(bus.dbus_we), 0);
        chk("rst_dbus_addr", bus.dbus_addr, 0);
        chk("rst_dbus_be", 32'(bus.dbus_be), 0);
        chk("rst_dbus_wdata", bus.dbus_wdata, 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_out", mem_out, 0);
        chk("rst_mem_gpr_we_", 32'(mem_gpr_we_), 0);
        chk("rst_mem_exc", 32'(mem_exc), 0);
        chk("rst_mem_exc_code", 32'(mem_exc_code), 0);
        chk("rst_mem_busy", 32'(mem_busy), 0);
        #5 reset = 1'b1;
        @(posedge clk); #1;

        // Pass-through ops (op 12 is treated as NOP).
        exp_res(32'h0000_1234, 1'b0, 5'd5, 30'h10, 1'b0, 2'd0, 1'b1);
        issue1(4'd0, 32'h0000_1234, 30'h10, 5'd5, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_no_dbus_req", 32'(bus.dbus_req), 0);
        @(posedge clk); #1;
        exp_res(32'hCAFE_0000, 1'b0, 5'd7, 30'h11, 1'b0, 2'd0, 1'b1);
        issue1(4'd12, 32'hCAFE_0000, 30'h11, 5'd7, 1'b0, 1'b0);

        // Loads.
        exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
        exp_res(32'hFFFF_FF80, 1'b0, 5'd1, 30'h20, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd1, 32'h103, 32'h0, 30'h20, 5'd1, 3, 32'h80FF_FFFF, -1, 3);
        exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
        exp_res(32'h0000_0034, 1'b0, 5'd2, 30'h21, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd4, 32'h102, 32'h0, 30'h21, 5'd2, 1, 32'h1234_5678, -1, 1);
        exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
        exp_res(32'hFFFF_8001, 1'b0, 5'd3, 30'h22, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd2, 32'h102, 32'h0, 30'h22, 5'd3, 0, 32'h8001_0000, -1, 0);
        exp_bus(32'h200, 4'b1111, 1'b0, 32'h0);
        exp_res(32'h0000_F00D, 1'b0, 5'd4, 30'h23, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd5, 32'h200, 32'h0, 30'h23, 5'd4, 2, 32'h7777_F00D, -1, 2);
        exp_bus(32'h300, 4'b1111, 1'b0, 32'h0);
        exp_res(32'hDEAD_BEEF, 1'b0, 5'd6, 30'h24, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd3, 32'h300, 32'h0, 30'h24, 5'd6, 1, 32'hDEAD_BEEF, -1, 1);

        // Stores: result carries the address, writeback disabled.
        exp_bus(32'h400, 4'b0010, 1'b1, 32'hA5A5_A5A5);
        exp_res(32'h0000_0401, 1'b1, 5'd8, 30'h30, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd6, 32'h401, 32'h0000_00A5, 30'h30, 5'd8, 1, 32'h0, -1, 1);
        exp_bus(32'h200, 4'b1100, 1'b1, 32'hABCD_ABCD);
        exp_res(32'h0000_0202, 1'b1, 5'd9, 30'h31, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd7, 32'h202, 32'h0000_ABCD, 30'h31, 5'd9, 2, 32'h0, -1, 2);
        exp_bus(32'h500, 4'b1111, 1'b1, 32'h1122_3344);
        exp_res(32'h0000_0500, 1'b1, 5'd10, 30'h32, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd8, 32'h500, 32'h1122_3344, 30'h32, 5'd10, 0, 32'h0, -1, 0);

        // Misaligned accesses: no bus request, exception next edge.
        exp_res(32'h0000_0101, 1'b1, 5'd11, 30'h40, 1'b1, 2'd1, 1'b1);
        issue1(4'd3, 32'h101, 30'h40, 5'd11, 1'b0, 1'b0);
        exp_res(32'h0000_0102, 1'b1, 5'd12, 30'h41, 1'b1, 2'd2, 1'b1);
        issue1(4'd8, 32'h102, 30'h41, 5'd12, 1'b0, 1'b0);
        exp_res(32'h0000_0101, 1'b1, 5'd13, 30'h42, 1'b1, 2'd1, 1'b1);
        issue1(4'd5, 32'h101, 30'h42, 5'd13, 1'b0, 1'b0);
        exp_res(32'h0000_0203, 1'b1, 5'd14, 30'h43, 1'b1, 2'd2, 1'b1);
        issue1(4'd7, 32'h203, 30'h43, 5'd14, 1'b0, 1'b0);
        @(negedge clk);
        chk("misaligned_no_dbus_req", 32'(bus.dbus_req), 0);
        @(posedge clk); #1;

        // Timeout after 4 BUSY cycles; then ack in the last cycle wins.
        exp_bus(32'h600, 4'b1111, 1'b0, 32'h0);
        exp_res(32'h0, 1'b1, 5'd15, 30'h50, 1'b1, 2'd3, 1'b0);
        mem_txn(4'd3, 32'h600, 32'h0, 30'h50, 5'd15, -1, 32'h0, -1, 4);
        exp_bus(32'h600, 4'b1111, 1'b0, 32'h0);
        exp_res(32'h0BAD_F00D, 1'b0, 5'd16, 30'h51, 1'b0, 2'd0, 1'b1);
        mem_txn(4'd3, 32'h600, 32'h0, 30'h51, 5'd16, 3, 32'h0BAD_F00D, -1, 3);

        // Flush mid-BUSY: transaction completes, no result.
        exp_bus(32'h700, 4'b1111, 1'b0, 32'h0);
        mem_txn(4'd3, 32'h700, 32'h0, 30'h60, 5'd17, 3, 32'h1111_1111, 1, 3);
        // Flush with timeout: no exception result either.
        exp_bus(32'h704, 4'b1111, 1'b1, 32'h9999_9999);
        mem_txn(4'd8, 32'h704, 32'h9999_9999, 30'h61, 5'd18, -1, 32'h0, 0, 4);

        // Flush in IDLE: neither result nor bus request.
        issue1(4'd0, 32'h0000_4321, 30'h62, 5'd19, 1'b0, 1'b1);
        issue1(4'd8, 32'h800, 30'h63, 5'd20, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_idle_no_req", 32'(bus.dbus_req), 0);
        chk("flush_idle_mem_en", 32'(mem_en), 0);
        @(posedge clk); #1;

        // Ack while IDLE is ignored.
        bus.dbus_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_busy", 32'(mem_busy), 0);
        @(posedge clk); #1;
        bus.dbus_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_mem_en", 32'(mem_en), 0);
        @(posedge clk); #1;

        // Reset during BUSY: outputs clear asynchronously, no result later.
        exp_bus(32'h900, 4'b1111, 1'b0, 32'h0);
        drive(4'd3, 32'h900, 32'h0, 30'h70, 5'd21, 1'b0);
        @(posedge clk); #1;
        ex_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("arst_dbus_req", 32'(bus.dbus_req), 0);
        chk("arst_dbus_addr", bus.dbus_addr, 0);
        chk("arst_mem_busy", 32'(mem_busy), 0);
        chk("arst_mem_out", mem_out, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.dbus_ack = 1'b1;
        @(posedge clk); #1;
        bus.dbus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_dbus_req", 32'(bus.dbus_req), 0);

        // Normal operation resumes.
        exp_res(32'h0000_00AA, 1'b1, 5'd22, 30'h80, 1'b0, 2'd0, 1'b1);
        issue1(4'd0, 32'h0000_00AA, 30'h80, 5'd22, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        chk("result_queue_empty", exp_q.size(), 0);
        chk("bus_queue_empty", bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of BUSY cycles without dbus_ack before the access aborts (range 1..255).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ex_en, ex_pc[29:0], ex_insn[31:0]  in  upstream EX-stage valid, word PC, instruction.
REQ-005 ex_alu_out[31:0]  in  effective byte address (mem ops) or ALU result (non-mem ops).
REQ-006 ex_gpr_we_ (1, active-low), ex_dst_addr[4:0]  in  upstream writeback control.
REQ-007 ex_mem_op[3:0], ex_gpr_data[31:0]  in  op code (0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW, 9-15 treated as NOP) and store data.
REQ-008 mem_flush  in  1  synchronous kill of the current/pending result.
REQ-009 dbus_req, dbus_we  out  1 each  data-bus request and write strobe.
REQ-010 dbus_addr[31:0], dbus_be[3:0], dbus_wdata[31:0]  out  word-aligned address (bits[1:0]=0), byte enables, lane-aligned store data.
REQ-011 dbus_ack  in  1, dbus_rdata[31:0]  in  32  completion strobe and read word.
REQ-012 mem_busy  out  1  combinational stall to upstream.
REQ-013 mem_en, mem_pc, mem_insn, mem_out[31:0], mem_gpr_we_, mem_dst_addr  out  registered stage outputs to writeback.
REQ-014 mem_exc  out  1, mem_exc_code[1:0]  out  exception flag; code 1 load misaligned, 2 store misaligned, 3 bus timeout.

Function
REQ-015 FSM states IDLE and BUSY; BUSY entered only from IDLE.
REQ-016 IDLE, ex_en=1, non-mem op: next edge mem_* <= ex_* (mem_out=ex_alu_out), mem_exc=0; latency 1.
REQ-017 IDLE, ex_en=0: next edge mem_en=0, other mem_* hold.
REQ-018 Misalignment: halfword ops with addr[0]=1, LW/SW with addr[1:0]!=0 -> no bus request; next edge mem_en=1, mem_exc=1, code 1/2, mem_gpr_we_=1, mem_out=address.
REQ-019 IDLE, ex_en=1, aligned mem op: next edge state=BUSY, request fields latched, timeout counter=0, mem_en=0.
REQ-020 BUSY: dbus_req=1 and all dbus_* outputs stable until the ack cycle; dbus_we=1 for SB/SH/SW.
REQ-021 dbus_be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads drive 4'b1111.
REQ-022 dbus_wdata: byte replicated in all 4 lanes for SB, halfword in both halves for SH, word for SW.
REQ-023 mem_busy = (state==BUSY) && !dbus_ack; upstream holds ex_* while mem_busy=1.
REQ-024 BUSY with dbus_ack=1: next edge state=IDLE, mem_en=1, mem_* from latched request; loads: mem_out = selected byte/halfword sign- (LB, LH) or zero-extended (LBU, LHU), LW full word; stores: mem_out=address, mem_gpr_we_=1.
REQ-025 Timeout counter increments each BUSY cycle without ack; when it equals TIMEOUT_CYCLES-1 and no ack: next edge state=IDLE, mem_en=1, mem_exc=1, code 3, mem_gpr_we_=1.
REQ-026 Ack and timeout in the same cycle: ack wins.
REQ-027 mem_flush in IDLE: next edge mem_en=0, no new request issued that cycle.
REQ-028 mem_flush in BUSY: bus transaction continues to ack/timeout (no cancellation); flush sticky-latched; completion produces mem_en=0, mem_exc=0.
REQ-029 dbus_ack while IDLE is ignored.

Reset
REQ-030 reset low: state=IDLE, counter=0, flush latch=0, all mem_* outputs 0, mem_exc_code=0, dbus_req=0, dbus_we=0, dbus_addr/be/wdata=0, mem_busy=0.
REQ-031 reset low during BUSY aborts the access immediately; no result is produced after release.

Verification
REQ-032 ADD-type op ex_alu_out=0x1234, ex_dst_addr=5, ex_gpr_we_=0 -> one edge later mem_en=1, mem_out=0x1234, mem_dst_addr=5, dbus_req=0.
REQ-033 LB addr 0x103, ack after 3 cycles with rdata 0x80FF_FFFF -> dbus_addr=0x100, mem_busy=1 for 3 cycles, mem_out=0xFFFF_FF80.
REQ-034 SH addr 0x202 data 0xABCD -> dbus_be=4'b1100, dbus_wdata=0xABCD_ABCD, dbus_we=1; on ack mem_en=1, mem_gpr_we_=1.
REQ-035 LW addr 0x101 -> no dbus_req, next edge mem_exc=1, code 1; SW addr 0x102 -> code 2.
REQ-036 LW, TIMEOUT_CYCLES=4, ack never -> 4 BUSY cycles, then mem_exc=1, code 3, state IDLE; repeat with ack in cycle 4 -> normal completion.
REQ-037 mem_flush pulsed mid-BUSY, ack later -> mem_en stays 0; reset asserted mid-BUSY -> dbus_req drops asynchronously, outputs zero.
